// File: rtl/uvmt_cv32e40s_pkg.sv
// Shared definitions for the cv32e40s OBI verification environment:
// master IDs and the default outstanding-transaction limit.
package uvmt_cv32e40s_pkg;

  typedef enum logic {
    OBI_ID_INSTR = 1'b0,
    OBI_ID_DATA  = 1'b1
  } obi_id_e;

  localparam int unsigned OBI_MAX_OUTSTANDING_DEFAULT = 2;

  function automatic obi_id_e obi_other_id(input obi_id_e id);
    return (id == OBI_ID_INSTR) ? OBI_ID_DATA : OBI_ID_INSTR;
  endfunction

endpackage

// File: rtl/cv32e40s_fv_obi_id_fifo.sv
// FIFO of master IDs for accepted-but-unanswered OBI transactions.
// A push and a pop in the same cycle are both applied.
module cv32e40s_fv_obi_id_fifo
  import uvmt_cv32e40s_pkg::*;
#(
  parameter int unsigned DEPTH = OBI_MAX_OUTSTANDING_DEFAULT
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    push_i,
  input  obi_id_e id_i,
  input  logic    pop_i,
  output logic    full_o,
  output logic    empty_o,
  output obi_id_e head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  obi_id_e          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= OBI_ID_INSTR;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= id_i;
      end
    end
  end

endmodule

// File: rtl/cv32e40s_fv_obi_arbiter.sv
// Two-to-one OBI arbiter: round-robin between instruction and data masters,
// holds an ungranted address phase, and routes responses by issue order.
module cv32e40s_fv_obi_arbiter
  import uvmt_cv32e40s_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = OBI_MAX_OUTSTANDING_DEFAULT
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [1:0]                        m_req_i,
  output logic [1:0]                        m_gnt_o,
  input  logic [1:0][ADDR_WIDTH-1:0]        m_addr_i,
  input  logic [1:0]                        m_we_i,
  input  logic [1:0][DATA_WIDTH/8-1:0]      m_be_i,
  input  logic [1:0][DATA_WIDTH-1:0]        m_wdata_i,
  output logic [1:0]                        m_rvalid_o,
  output logic [1:0][DATA_WIDTH-1:0]        m_rdata_o,
  output logic [1:0]                        m_err_o,
  output logic                              s_req_o,
  input  logic                              s_gnt_i,
  output logic [ADDR_WIDTH-1:0]             s_addr_o,
  output logic                              s_we_o,
  output logic [DATA_WIDTH/8-1:0]           s_be_o,
  output logic [DATA_WIDTH-1:0]             s_wdata_o,
  input  logic                              s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]             s_rdata_i,
  input  logic                              s_err_i,
  output logic                              proto_err_o
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  obi_id_e                 sel_q, sel_d;
  obi_id_e                 last_q, last_d;
  logic                    lock_q, lock_d;
  logic                    proto_err_q, proto_err_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [BE_WIDTH-1:0]     be_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  obi_id_e                 owner;
  logic                    blocked;
  logic                    handshake;
  logic                    resp_valid;
  logic                    lock_drop;
  logic                    lock_change;
  logic                    spurious_rsp;

  logic                    fifo_full;
  logic                    fifo_empty;
  obi_id_e                 fifo_head;

  // A pending address phase pins the owner; otherwise round-robin on ties.
  always_comb begin
    owner = obi_other_id(last_q);
    if (lock_q) begin
      owner = sel_q;
    end else if (m_req_i == 2'b01) begin
      owner = OBI_ID_INSTR;
    end else if (m_req_i == 2'b10) begin
      owner = OBI_ID_DATA;
    end
  end

  assign blocked   = fifo_full;
  assign s_req_o   = ~blocked & m_req_i[owner];
  assign handshake = s_req_o & s_gnt_i;

  assign s_addr_o  = m_addr_i[owner];
  assign s_we_o    = m_we_i[owner];
  assign s_be_o    = m_be_i[owner];
  assign s_wdata_o = m_wdata_i[owner];

  always_comb begin
    m_gnt_o        = '0;
    m_gnt_o[owner] = handshake;
  end

  assign resp_valid = s_rvalid_i & ~fifo_empty;

  always_comb begin
    m_rvalid_o            = '0;
    m_rvalid_o[fifo_head] = resp_valid;
    for (int m = 0; m < 2; m++) begin
      m_rdata_o[m] = resp_valid ? s_rdata_i : '0;
      m_err_o[m]   = s_err_i & m_rvalid_o[m];
    end
  end

  cv32e40s_fv_obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (handshake),
    .id_i    (owner),
    .pop_i   (resp_valid),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  assign lock_d = s_req_o & ~s_gnt_i;
  assign sel_d  = lock_d ? owner : sel_q;
  assign last_d = handshake ? owner : last_q;

  // The held address phase is compared against what was presented when it locked.
  assign lock_drop    = lock_q & ~m_req_i[sel_q];
  assign lock_change  = lock_q & m_req_i[sel_q] &
                        ((m_addr_i[sel_q] != addr_q) | (m_we_i[sel_q] != we_q) |
                         (m_be_i[sel_q] != be_q) | (m_wdata_i[sel_q] != wdata_q));
  assign spurious_rsp = s_rvalid_i & fifo_empty;
  assign proto_err_d  = proto_err_q | lock_drop | lock_change | spurious_rsp;

  assign proto_err_o = proto_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_q       <= OBI_ID_INSTR;
      last_q      <= OBI_ID_DATA;
      lock_q      <= 1'b0;
      proto_err_q <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
    end else begin
      sel_q       <= sel_d;
      last_q      <= last_d;
      lock_q      <= lock_d;
      proto_err_q <= proto_err_d;
      if (lock_d) begin
        addr_q  <= m_addr_i[owner];
        we_q    <= m_we_i[owner];
        be_q    <= m_be_i[owner];
        wdata_q <= m_wdata_i[owner];
      end
    end
  end

endmodule

// File: tb/tb_cv32e40s_fv_obi_arbiter.sv
// Bench for the two-to-one OBI arbiter: directed scenarios with literal
// expectations plus random traffic checked against a transaction-level model.
module tb_cv32e40s_fv_obi_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]             m_req_i = '0;
  logic [1:0]             m_gnt_o;
  logic [1:0][AW-1:0]     m_addr_i = '0;
  logic [1:0]             m_we_i = '0;
  logic [1:0][DW/8-1:0]   m_be_i = '0;
  logic [1:0][DW-1:0]     m_wdata_i = '0;
  logic [1:0]             m_rvalid_o;
  logic [1:0][DW-1:0]     m_rdata_o;
  logic [1:0]             m_err_o;
  logic                   s_req_o;
  logic                   s_gnt_i = 1'b0;
  logic [AW-1:0]          s_addr_o;
  logic                   s_we_o;
  logic [DW/8-1:0]        s_be_o;
  logic [DW-1:0]          s_wdata_o;
  logic                   s_rvalid_i = 1'b0;
  logic [DW-1:0]          s_rdata_i = '0;
  logic                   s_err_i = 1'b0;
  logic                   proto_err_o;

  cv32e40s_fv_obi_arbiter #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .m_req_i     (m_req_i),
    .m_gnt_o     (m_gnt_o),
    .m_addr_i    (m_addr_i),
    .m_we_i      (m_we_i),
    .m_be_i      (m_be_i),
    .m_wdata_i   (m_wdata_i),
    .m_rvalid_o  (m_rvalid_o),
    .m_rdata_o   (m_rdata_o),
    .m_err_o     (m_err_o),
    .s_req_o     (s_req_o),
    .s_gnt_i     (s_gnt_i),
    .s_addr_o    (s_addr_o),
    .s_we_o      (s_we_o),
    .s_be_o      (s_be_o),
    .s_wdata_o   (s_wdata_o),
    .s_rvalid_i  (s_rvalid_i),
    .s_rdata_i   (s_rdata_i),
    .s_err_i     (s_err_i),
    .proto_err_o (proto_err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding IDs in issue order, pending (ungranted) owner,
  // last winner and the sticky error flag.
  logic [0:0]      exp_q[$];
  int              pend = -1;
  int              last = 1;
  bit              perr = 1'b0;
  logic [1:0]      hs = '0;
  logic [AW-1:0]   p_addr;
  logic            p_we;
  logic [DW/8-1:0] p_be;
  logic [DW-1:0]   p_wdata;
  int              owner;
  bit              full;
  bit              e_sreq;
  logic [1:0]      e_gnt;
  logic [1:0]      e_rv;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      pend = -1;
      last = 1;
      perr = 1'b0;
      hs   = '0;
    end else begin
      full  = (exp_q.size() >= MAXO);
      owner = -1;
      if (pend >= 0)            owner = pend;
      else if (m_req_i == 2'b01) owner = 0;
      else if (m_req_i == 2'b10) owner = 1;
      else if (m_req_i == 2'b11) owner = 1 - last;
      e_sreq = !full && (owner >= 0) && m_req_i[owner];
      check("s_req", s_req_o, e_sreq);
      if (full) begin
        check("gnt_blocked", m_gnt_o, 2'b00);
      end else if (e_sreq) begin
        e_gnt = '0;
        e_gnt[owner] = s_gnt_i;
        check("gnt", m_gnt_o, e_gnt);
        check("s_addr", s_addr_o, m_addr_i[owner]);
        check("s_we", s_we_o, m_we_i[owner]);
        check("s_be", s_be_o, m_be_i[owner]);
        check("s_wdata", s_wdata_o, m_wdata_i[owner]);
      end
      e_rv = '0;
      if (s_rvalid_i && exp_q.size() > 0) e_rv[exp_q[0]] = 1'b1;
      check("rvalid", m_rvalid_o, e_rv);
      if (e_rv != 2'b00) begin
        check("rdata", m_rdata_o[exp_q[0]], s_rdata_i);
        check("rerr", m_err_o[exp_q[0]], s_err_i);
      end
      check("proto_err", proto_err_o, perr);

      if (pend >= 0 && (!m_req_i[pend] || m_addr_i[pend] != p_addr || m_we_i[pend] != p_we ||
                        m_be_i[pend] != p_be || m_wdata_i[pend] != p_wdata)) perr = 1'b1;
      if (s_rvalid_i && exp_q.size() == 0) perr = 1'b1;
      hs = '0;
      if (s_rvalid_i && exp_q.size() > 0) void'(exp_q.pop_front());
      if (e_sreq && s_gnt_i) begin
        hs[owner] = 1'b1;
        exp_q.push_back(owner[0]);
        last = owner;
        pend = -1;
      end else if (e_sreq) begin
        pend    = owner;
        p_addr  = m_addr_i[owner];
        p_we    = m_we_i[owner];
        p_be    = m_be_i[owner];
        p_wdata = m_wdata_i[owner];
      end else begin
        pend = -1;
      end
    end
  end

  // driver tasks
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic req, input logic [AW-1:0] a, input logic w,
                       input logic [DW/8-1:0] b, input logic [DW-1:0] d);
    m_req_i[m]   = req;
    m_addr_i[m]  = a;
    m_we_i[m]    = w;
    m_be_i[m]    = b;
    m_wdata_i[m] = d;
  endtask

  task automatic idle_inputs();
    m_req_i    = '0;
    m_addr_i   = '0;
    m_we_i     = '0;
    m_be_i     = '0;
    m_wdata_i  = '0;
    s_gnt_i    = 1'b0;
    s_rvalid_i = 1'b0;
    s_rdata_i  = '0;
    s_err_i    = 1'b0;
  endtask

  task automatic do_reset();
    adv();
    reset_n = 1'b0;
    idle_inputs();
    settle();
    check("rst_gnt", m_gnt_o, 2'b00);
    check("rst_rvalid", m_rvalid_o, 2'b00);
    check("rst_sreq", s_req_o, 1'b0);
    check("rst_perr", proto_err_o, 1'b0);
    check("rst_saddr", s_addr_o, '0);
    check("rst_rdata", m_rdata_o, '0);
    adv();
    reset_n = 1'b1;
  endtask

  bit              act [2];
  logic [AW-1:0]   r_addr [2];

  initial begin
    do_reset();

    // single data write, grant in the third request cycle
    set_m(1, 1'b1, 32'h100, 1'b1, 4'hF, 32'hDEAD_BEEF);
    for (int k = 0; k < 3; k++) begin
      s_gnt_i = (k == 2);
      settle();
      check("t1_saddr", s_addr_o, 32'h100);
      check("t1_gnt", m_gnt_o, (k == 2) ? 2'b10 : 2'b00);
      adv();
    end
    set_m(1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'h55;
    settle();
    check("t1_rvalid", m_rvalid_o, 2'b10);
    check("t1_rdata", m_rdata_o[1], 32'h55);
    adv();
    idle_inputs();

    // continuous contention alternates, instruction first
    do_reset();
    set_m(0, 1'b1, 32'h200, 1'b0, 4'hF, 32'h0);
    set_m(1, 1'b1, 32'h300, 1'b1, 4'h3, 32'h1234);
    s_gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_rvalid_i = (k >= 1);
      s_rdata_i  = 32'(k);
      settle();
      check("t2_gnt", m_gnt_o, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k >= 1) check("t2_rvalid", m_rvalid_o, (k % 2 == 1) ? 2'b01 : 2'b10);
      adv();
    end
    m_req_i = '0; s_gnt_i = 1'b0; s_rvalid_i = 1'b1;
    settle();
    check("t2_drain", m_rvalid_o, 2'b10);
    adv();
    idle_inputs();

    // data locked, instruction must wait
    do_reset();
    set_m(1, 1'b1, 32'h400, 1'b1, 4'hF, 32'hAAAA);
    settle();
    check("t3_gnt0", m_gnt_o, 2'b00);
    adv();
    set_m(0, 1'b1, 32'h500, 1'b0, 4'hF, 32'h0);
    settle();
    check("t3_addr_held", s_addr_o, 32'h400);
    check("t3_gnt1", m_gnt_o, 2'b00);
    adv();
    s_gnt_i = 1'b1;
    settle();
    check("t3_gnt2", m_gnt_o, 2'b10);
    adv();
    m_req_i[1] = 1'b0;
    settle();
    check("t3_gnt3", m_gnt_o, 2'b01);
    adv();
    m_req_i = '0; s_gnt_i = 1'b0; s_rvalid_i = 1'b1;
    settle();
    check("t3_rsp0", m_rvalid_o, 2'b10);
    adv();
    settle();
    check("t3_rsp1", m_rvalid_o, 2'b01);
    adv();
    idle_inputs();

    // FIFO full blocks until the first response
    do_reset();
    set_m(0, 1'b1, 32'h600, 1'b0, 4'hF, 32'h0);
    set_m(1, 1'b1, 32'h700, 1'b0, 4'hF, 32'h0);
    s_gnt_i = 1'b1;
    settle(); check("t4_g0", m_gnt_o, 2'b01); adv();
    settle(); check("t4_g1", m_gnt_o, 2'b10); adv();
    settle(); check("t4_blk0", s_req_o, 1'b0); adv();
    settle(); check("t4_blk1", m_gnt_o, 2'b00); adv();
    s_rvalid_i = 1'b1; s_rdata_i = 32'h77;
    settle();
    check("t4_rv", m_rvalid_o, 2'b01);
    check("t4_rdata", m_rdata_o[0], 32'h77);
    check("t4_blk2", s_req_o, 1'b0);
    adv();
    s_rvalid_i = 1'b0;
    settle();
    check("t4_unblk", m_gnt_o, 2'b01);
    adv();

    // interleaved grants, ordered responses
    do_reset();
    set_m(0, 1'b1, 32'h800, 1'b0, 4'hF, 32'h0);
    s_gnt_i = 1'b1;
    settle(); check("t5_g0", m_gnt_o, 2'b01); adv();
    set_m(0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    set_m(1, 1'b1, 32'h900, 1'b0, 4'hF, 32'h0);
    settle(); check("t5_g1", m_gnt_o, 2'b10); adv();
    idle_inputs();
    s_rvalid_i = 1'b1; s_rdata_i = 32'hA;
    settle();
    check("t5_rvA", m_rvalid_o, 2'b01);
    check("t5_dA", m_rdata_o[0], 32'hA);
    adv();
    s_rdata_i = 32'hB;
    settle();
    check("t5_rvB", m_rvalid_o, 2'b10);
    check("t5_dB", m_rdata_o[1], 32'hB);
    adv();

    // spurious response sets the sticky error
    s_rdata_i = 32'hC;
    settle();
    check("t6_norv", m_rvalid_o, 2'b00);
    check("t6_perr0", proto_err_o, 1'b0);
    adv();
    s_rvalid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle(); check("t6_perr_sticky", proto_err_o, 1'b1); adv();
    end
    do_reset();

    // locked master dropping its request
    set_m(1, 1'b1, 32'hA00, 1'b0, 4'hF, 32'h0);
    adv();
    m_req_i[1] = 1'b0;
    adv();
    settle(); check("t7_drop_perr", proto_err_o, 1'b1);
    do_reset();

    // locked master changing its address
    set_m(1, 1'b1, 32'hB00, 1'b0, 4'hF, 32'h0);
    adv();
    m_addr_i[1] = 32'hB04;
    adv();
    settle(); check("t8_chg_perr", proto_err_o, 1'b1);
    do_reset();

    // random compliant traffic
    act[0] = 1'b0; act[1] = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      adv();
      for (int m = 0; m < 2; m++) begin
        if (act[m] && hs[m]) act[m] = 1'b0;
        if (!act[m] && $urandom_range(0, 2) != 0) begin
          act[m]    = 1'b1;
          r_addr[m] = $urandom;
          set_m(m, 1'b1, r_addr[m], 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
        end
        m_req_i[m] = act[m];
      end
      s_gnt_i    = 1'($urandom_range(0, 1));
      s_rvalid_i = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
      s_rdata_i  = $urandom;
      s_err_i    = ($urandom_range(0, 3) == 0);
    end
    adv();
    idle_inputs();
    settle();
    check("rand_no_perr", proto_err_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40s_fv_obi_arbiter.md
# cv32e40s_fv_obi_arbiter

Two-to-one OBI arbiter for the cv32e40s formal and simulation environment. It shares a single OBI memory slave between the core's instruction-fetch and data OBI masters. It holds each requester's address phase stable until the slave grants it. It tracks outstanding transactions so that every response returns to the master that issued the request. The block sits between the core's two OBI master ports and the memory model.

## Interface
Parameters:
- ADDR_WIDTH, 32, OBI address width
- DATA_WIDTH, 32, OBI data width
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered transactions; legal range 1..4

Ports (m = 0 instruction, m = 1 data; each m-port is one bit or field per master):
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- m_req_i  in  2  master address-phase request
- m_gnt_o  out  2  master grant
- m_addr_i  in  2×ADDR_WIDTH  master address
- m_we_i  in  2  write enable
- m_be_i  in  2×DATA_WIDTH/8  byte enables
- m_wdata_i  in  2×DATA_WIDTH  write data
- m_rvalid_o  out  2  response valid
- m_rdata_o  out  2×DATA_WIDTH  response data
- m_err_o  out  2  response error
- s_req_o  out  1  slave request
- s_gnt_i  in  1  slave grant
- s_addr_o, s_we_o, s_be_o, s_wdata_o  out  as above  selected address phase
- s_rvalid_i  in  1  slave response valid
- s_rdata_i  in  DATA_WIDTH  slave response data
- s_err_i  in  1  slave response error
- proto_err_o  out  1  sticky protocol-violation flag

## Operation
- State: sel_q (current owner), lock_q (address phase pending), last_q (last granted master), and an ID FIFO of depth MAX_OUTSTANDING holding 1-bit master IDs.
- Arbitration:
  - If lock_q=1, the owner is sel_q.
  - Otherwise the owner is the single requester, if only one master requests.
  - Otherwise, with both requesting, the owner is the master ≠ last_q (round-robin).
- Blocking: when the FIFO is full, s_req_o=0 and both m_gnt_o=0, even if s_rvalid_i=1 in the same cycle.
- Outputs when not blocked:
  - s_req_o = m_req_i[owner].
  - s_addr/we/be/wdata = owner's fields.
  - m_gnt_o[owner] = s_gnt_i.
  - The other m_gnt_o bit = 0.
- Lock:
  - lock_q sets when s_req_o=1 and s_gnt_i=0; sel_q captures the owner at that point.
  - lock_q clears on the grant handshake.
  - The arbiter never switches owner while a request is ungranted.
- On a handshake (s_req_o & s_gnt_i):
  - Push the owner ID into the FIFO.
  - last_q ← owner.
- Response routing:
  - If s_rvalid_i=1 and the FIFO is non-empty, pop the FIFO.
  - m_rvalid_o[head] = 1. Both m_rdata_o ports are driven with s_rdata_i and both m_err_o ports with s_err_i, qualified by rvalid.
  - Push and pop in the same cycle are both applied; the count is unchanged.
- Protocol errors: any of the following sets proto_err_o, which stays set until reset:
  - s_rvalid_i with an empty FIFO; the response is dropped.
  - A locked master deasserting m_req_i.
  - A locked master changing its address-phase fields.

## Timing
- Reset values:
  - All m_gnt_o, m_rvalid_o, s_req_o, and proto_err_o are 0.
  - All data outputs are 0.
  - lock_q=0, last_q=1 (instruction port wins the first tie), FIFO empty.
- Grant path s_gnt_i→m_gnt_o is combinational (zero latency).
- Response path s_rvalid_i→m_rvalid_o is combinational.
- The earliest response is the cycle after the grant. A response in the grant cycle itself is a protocol error.
- Throughput: one handshake per cycle while the FIFO is not full.
- Reset asserted mid-transaction clears the FIFO and the lock immediately; pending responses are forgotten.

## Structure
- The shared package uvmt_cv32e40s_pkg holds:
  - the OBI master-ID typedef (instr=0, data=1);
  - the MAX_OUTSTANDING default constant.
- One sub-module: cv32e40s_fv_obi_id_fifo. It is a parameterised ID FIFO with push, pop, full, empty, and head outputs, and it handles simultaneous push/pop.
- Arbitration and lock logic live in the top module.

## Test plan
- Single data write at addr 0x100, with gnt arriving 3 cycles after req → m_gnt_o[1] pulses in the 3rd cycle, the address phase is stable throughout, and the FIFO holds ID 1.
- Both masters request continuously and gnt=1 every cycle → grants alternate 0,1,0,1; the first grant goes to instr.
- Data locked (gnt held low), then instr requests → instr is not granted until data's handshake completes.
- MAX_OUTSTANDING=2: two grants with no rvalid → s_req_o=0 until the first rvalid, and the response goes to the first-granted master.
- Interleaved instr then data grants, followed by rvalids carrying rdata 0xA and 0xB → 0xA goes to instr and 0xB to data, in order.
- s_rvalid_i with an empty FIFO → no m_rvalid_o, and proto_err_o rises and stays high until reset_n=0.
